// File: rtl/lb2apb.sv
// ---------------------------------------------------------------------------
// lb2apb : local register bus (LB) responder -> AMBA APB3 requester bridge
//
// Accepts one LB read or write at a time, runs it as a single APB transfer
// (SETUP then ACCESS), and returns a one-cycle completion pulse on the LB
// side. The ACCESS phase can be bounded by a cycle timeout.
//
// Parameters
//   ADDR_W   address width on both sides
//   DATA_W   data width (8, 16 or 32); STRB_W = DATA_W/8
//   TIMEOUT  max ACCESS cycles waiting for pready; 0 disables the timeout
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   LB write        waddr, wdata, wstrb, wen (held until wready), wready
//   LB read         raddr, ren (held until rvalid), rdata, rvalid
//   err             error flag, meaningful only with wready/rvalid
//                   (PSLVERR from the slave, or timeout)
//   APB requester   psel, penable, pwrite, paddr, pwdata, pstrb,
//                   prdata, pready, pslverr
// ---------------------------------------------------------------------------
module lb2apb #(
  parameter  int ADDR_W  = 16,
  parameter  int DATA_W  = 32,
  parameter  int TIMEOUT = 255,
  localparam int STRB_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  // LB write channel
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wen,
  input  logic [STRB_W-1:0] wstrb,
  output logic              wready,
  // LB read channel
  input  logic [ADDR_W-1:0] raddr,
  input  logic              ren,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              err,
  // APB requester
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic [STRB_W-1:0] pstrb,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  // Timeout counter only needs to reach TIMEOUT-1: the abort decision is
  // taken in the ACCESS cycle in which the counter holds that value.
  localparam bit TO_EN   = (TIMEOUT > 0);
  localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TO_LAST = TO_EN ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] tcnt;
  logic             timeout_hit;

  // True in the last ACCESS cycle the slave is allowed before an abort.
  assign timeout_hit = TO_EN && (tcnt == CNT_W'(TO_LAST));

  // NOTE: all state and outputs are registered with non-blocking assignments,
  // so every read of a register in this block sees its value from before the
  // clock edge, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tcnt    <= '0;
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
      pstrb   <= '0;
      wready  <= 1'b0;
      rvalid  <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
    end else begin
      // Response flags default low so they can only ever be a single-cycle
      // pulse; they are raised on the transition into RESP.
      wready <= 1'b0;
      rvalid <= 1'b0;
      err    <= 1'b0;

      case (state)
        IDLE: begin
          // Writes win when both requests are present; the read request is
          // still held by the initiator and is picked up on the next visit.
          if (wen) begin
            paddr  <= waddr;
            pwdata <= wdata;
            pstrb  <= wstrb;
            pwrite <= 1'b1;
            psel   <= 1'b1;
            state  <= SETUP;
          end else if (ren) begin
            paddr  <= raddr;
            pstrb  <= '1;
            pwrite <= 1'b0;
            psel   <= 1'b1;
            state  <= SETUP;
          end
        end

        SETUP: begin
          penable <= 1'b1;
          tcnt    <= '0;
          state   <= ACCESS;
        end

        ACCESS: begin
          // A ready slave beats the timeout in the same cycle.
          if (pready) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            err     <= pslverr;
            wready  <= pwrite;
            rvalid  <= ~pwrite;
            if (!pwrite) begin
              rdata <= prdata;
            end
            state <= RESP;
          end else if (timeout_hit) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            err     <= 1'b1;
            wready  <= pwrite;
            rvalid  <= ~pwrite;
            if (!pwrite) begin
              rdata <= '0;
            end
            state <= RESP;
          end else if (TO_EN) begin
            tcnt <= tcnt + CNT_W'(1);
          end
        end

        RESP: begin
          // The pulse raised on entry is cleared by the defaults above.
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lb2apb.sv
// ---------------------------------------------------------------------------
// tb_lb2apb : self-checking bench for lb2apb (TIMEOUT overridden to 8)
//
// A behavioural APB slave answers transfers with a configurable number of
// wait states, PSLVERR and read data, and records what it saw in SETUP.
// Expected latency, ACCESS length, error and read data are computed from the
// bridge's documented behaviour with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_lb2apb;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] waddr = '0;
  logic [DW-1:0] wdata = '0;
  logic          wen = 1'b0;
  logic [SW-1:0] wstrb = '0;
  logic          wready;
  logic [AW-1:0] raddr = '0;
  logic          ren = 1'b0;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          err;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [SW-1:0] pstrb;
  logic [DW-1:0] prdata = '0;
  logic          pready = 1'b0;
  logic          pslverr = 1'b0;

  int total = 0;
  int bad   = 0;

  lb2apb #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(TO)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .waddr  (waddr),
    .wdata  (wdata),
    .wen    (wen),
    .wstrb  (wstrb),
    .wready (wready),
    .raddr  (raddr),
    .ren    (ren),
    .rdata  (rdata),
    .rvalid (rvalid),
    .err    (err),
    .psel   (psel),
    .penable(penable),
    .pwrite (pwrite),
    .paddr  (paddr),
    .pwdata (pwdata),
    .pstrb  (pstrb),
    .prdata (prdata),
    .pready (pready),
    .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  // ------------------------------------------------------------------------
  // Behavioural APB slave, acting on the falling edge.
  // ------------------------------------------------------------------------
  int            cfg_waits = 0;
  bit            cfg_err = 1'b0;
  logic [DW-1:0] cfg_rdata = '0;
  int            waits_left = 0;
  int            acc_cnt = 0;
  logic [AW-1:0] seen_addr = '0;
  logic          seen_write = 1'b0;
  logic [DW-1:0] seen_wdata = '0;
  logic [SW-1:0] seen_strb = '0;
  bit            apb_unstable = 1'b0;
  logic [AW:0]   done_log[$];

  always @(negedge clk) begin
    if (psel && !penable) begin
      seen_addr    = paddr;
      seen_write   = pwrite;
      seen_wdata   = pwdata;
      seen_strb    = pstrb;
      apb_unstable = 1'b0;
      acc_cnt      = 0;
      waits_left   = cfg_waits;
      pready       = 1'b0;
      pslverr      = 1'b0;
    end else if (psel && penable) begin
      acc_cnt++;
      if (paddr !== seen_addr || pwrite !== seen_write ||
          pwdata !== seen_wdata || pstrb !== seen_strb)
        apb_unstable = 1'b1;
      if (waits_left == 0) begin
        pready  = 1'b1;
        pslverr = cfg_err;
        prdata  = pwrite ? DW'($urandom) : cfg_rdata;
        done_log.push_back({pwrite, paddr});
      end else begin
        waits_left--;
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = DW'($urandom);
      end
    end else begin
      pready  = 1'b0;
      pslverr = 1'b0;
    end
  end

  // ------------------------------------------------------------------------
  // Reference model: latency and ACCESS length from the wait-state count.
  // ------------------------------------------------------------------------
  logic [DW-1:0] model_rdata = '0;

  function automatic int exp_lat(input int w);
    return (w < TO) ? 3 + w : 2 + TO;
  endfunction

  function automatic int exp_acc(input int w);
    return (w < TO) ? w + 1 : TO;
  endfunction

  // LB driver: one request, held until its pulse, returns what was seen.
  task automatic lb_xact(input bit is_wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [SW-1:0] strb,
                         input int waits, input bit slv_err,
                         input logic [DW-1:0] prd, output int lat,
                         output logic got_wr, output logic got_rd,
                         output logic got_err, output logic [DW-1:0] got_rdata,
                         output logic post_busy);
    cfg_waits = waits;
    cfg_err   = slv_err;
    cfg_rdata = prd;
    @(negedge clk);
    if (is_wr) begin
      waddr = addr; wdata = data; wstrb = strb; wen = 1'b1;
    end else begin
      raddr = addr; ren = 1'b1;
    end
    lat = -1; got_wr = 1'b0; got_rd = 1'b0; got_err = 1'b0; got_rdata = '0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) begin
        // Request is latched by now; later LB changes must be ignored.
        waddr = AW'($urandom); wdata = DW'($urandom);
        wstrb = SW'($urandom); raddr = AW'($urandom);
      end
      if (wready || rvalid) begin
        lat = n; got_wr = wready; got_rd = rvalid;
        got_err = err; got_rdata = rdata;
        break;
      end
    end
    wen = 1'b0;
    ren = 1'b0;
    @(negedge clk);
    post_busy = wready | rvalid | err | psel;
  endtask

  // ------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({psel, penable, pwrite, wready, rvalid, err} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {psel, penable, pwrite, wready, rvalid, err});
    end
    total++;
    if ({paddr, pwdata, pstrb, rdata} !== '0) begin
      bad++;
      $display("FAIL reset_data: got paddr=%h pwdata=%h pstrb=%h rdata=%h want 0",
               paddr, pwdata, pstrb, rdata);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({psel, wready, rvalid, err} !== 4'b0) begin
      bad++;
      $display("FAIL idle_after_reset: got %b want 0000",
               {psel, wready, rvalid, err});
    end
  endtask

  task automatic test_write_basic();
    int lat; logic gw, gr, ge, pb; logic [DW-1:0] gd;
    lb_xact(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 0, 1'b0, '0,
            lat, gw, gr, ge, gd, pb);
    total++;
    if (lat !== 3 || gw !== 1'b1 || gr !== 1'b0 || ge !== 1'b0) begin
      bad++;
      $display("FAIL write_resp: got lat=%0d wready=%b rvalid=%b err=%b want 3 1 0 0",
               lat, gw, gr, ge);
    end
    total++;
    if (seen_addr !== 16'h0010 || seen_write !== 1'b1 || seen_strb !== 4'hF ||
        seen_wdata !== 32'hDEADBEEF || apb_unstable !== 1'b0) begin
      bad++;
      $display("FAIL write_apb: got addr=%h wr=%b strb=%h data=%h unstable=%b",
               seen_addr, seen_write, seen_strb, seen_wdata, apb_unstable);
    end
    total++;
    if (pb !== 1'b0) begin
      bad++;
      $display("FAIL write_after_pulse: got busy=%b want 0", pb);
    end
  endtask

  task automatic test_read_waits();
    int lat; logic gw, gr, ge, pb; logic [DW-1:0] gd;
    lb_xact(1'b0, 16'h0024, '0, '0, 4, 1'b0, 32'h12345678,
            lat, gw, gr, ge, gd, pb);
    model_rdata = 32'h12345678;
    total++;
    if (acc_cnt !== 5) begin
      bad++;
      $display("FAIL read_penable_cycles: got %0d want 5", acc_cnt);
    end
    total++;
    if (lat !== 7 || gr !== 1'b1 || gw !== 1'b0 || ge !== 1'b0 ||
        gd !== 32'h12345678) begin
      bad++;
      $display("FAIL read_resp: got lat=%0d rvalid=%b wready=%b err=%b rdata=%h want 7 1 0 0 12345678",
               lat, gr, gw, ge, gd);
    end
    total++;
    if (seen_addr !== 16'h0024 || seen_write !== 1'b0 || seen_strb !== 4'hF ||
        apb_unstable !== 1'b0 || pb !== 1'b0) begin
      bad++;
      $display("FAIL read_apb: got addr=%h wr=%b strb=%h unstable=%b busy=%b",
               seen_addr, seen_write, seen_strb, apb_unstable, pb);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] rd;
    logic [DW-1:0] got_rd;
    logic          got_e;
    int            n_w;
    int            n_r;
    rd = 32'h0BADCAFE; got_rd = '0; got_e = 1'b1; n_w = -1; n_r = -1;
    cfg_waits = 0; cfg_err = 1'b0; cfg_rdata = rd;
    done_log.delete();
    @(negedge clk);
    waddr = 16'h0004; wdata = 32'hA5A50F0F; wstrb = 4'hF; wen = 1'b1;
    raddr = 16'h0008; ren = 1'b1;
    for (int n = 1; n <= 40 && n_r < 0; n++) begin
      @(negedge clk);
      if (wready) begin n_w = n; wen = 1'b0; end
      if (rvalid) begin n_r = n; got_rd = rdata; got_e = err; ren = 1'b0; end
    end
    wen = 1'b0;
    ren = 1'b0;
    @(negedge clk);
    model_rdata = rd;
    total++;
    if (n_w !== 3 || n_r !== 7) begin
      bad++;
      $display("FAIL b2b_timing: got wready@%0d rvalid@%0d want 3 7", n_w, n_r);
    end
    total++;
    if (got_rd !== rd || got_e !== 1'b0) begin
      bad++;
      $display("FAIL b2b_read: got rdata=%h err=%b want %h 0", got_rd, got_e, rd);
    end
    total++;
    if (done_log.size() != 2 || done_log[0] !== {1'b1, 16'h0004} ||
        done_log[1] !== {1'b0, 16'h0008}) begin
      bad++;
      $display("FAIL b2b_order: got %0d transfers first=%h want write@4 then read@8",
               done_log.size(), done_log.size() > 0 ? done_log[0] : '0);
    end
  endtask

  task automatic test_slverr();
    int lat; logic gw, gr, ge, pb; logic [DW-1:0] gd;
    lb_xact(1'b1, 16'h0100, 32'h11112222, 4'h3, 1, 1'b1, '0,
            lat, gw, gr, ge, gd, pb);
    total++;
    if (gw !== 1'b1 || ge !== 1'b1 || lat !== 4) begin
      bad++;
      $display("FAIL slverr_write: got wready=%b err=%b lat=%0d want 1 1 4",
               gw, ge, lat);
    end
    total++;
    if (pb !== 1'b0) begin
      bad++;
      $display("FAIL slverr_err_held: got busy=%b want 0", pb);
    end
    lb_xact(1'b1, 16'h0104, 32'h33334444, 4'hC, 0, 1'b0, '0,
            lat, gw, gr, ge, gd, pb);
    total++;
    if (gw !== 1'b1 || ge !== 1'b0) begin
      bad++;
      $display("FAIL slverr_next_clean: got wready=%b err=%b want 1 0", gw, ge);
    end
  endtask

  task automatic test_timeout();
    int lat; logic gw, gr, ge, pb; logic [DW-1:0] gd;
    // One wait short of the limit: must still succeed.
    lb_xact(1'b0, 16'h0200, '0, '0, TO - 1, 1'b0, 32'hCAFEF00D,
            lat, gw, gr, ge, gd, pb);
    model_rdata = 32'hCAFEF00D;
    total++;
    if (lat !== exp_lat(TO - 1) || acc_cnt !== TO || ge !== 1'b0 ||
        gd !== 32'hCAFEF00D) begin
      bad++;
      $display("FAIL timeout_edge: got lat=%0d acc=%0d err=%b rdata=%h want %0d %0d 0 cafef00d",
               lat, acc_cnt, ge, gd, exp_lat(TO - 1), TO);
    end
    // Slave never ready: abort after TO ACCESS cycles.
    lb_xact(1'b0, 16'h0204, '0, '0, 100, 1'b0, 32'h77777777,
            lat, gw, gr, ge, gd, pb);
    model_rdata = '0;
    total++;
    if (acc_cnt !== TO || lat !== 2 + TO) begin
      bad++;
      $display("FAIL timeout_len: got acc=%0d lat=%0d want %0d %0d",
               acc_cnt, lat, TO, 2 + TO);
    end
    total++;
    if (gr !== 1'b1 || ge !== 1'b1 || gd !== '0 || pb !== 1'b0) begin
      bad++;
      $display("FAIL timeout_resp: got rvalid=%b err=%b rdata=%h busy=%b want 1 1 0 0",
               gr, ge, gd, pb);
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic gw, gr, ge, pb; logic [DW-1:0] gd;
    cfg_waits = 50; cfg_err = 1'b0;
    @(negedge clk);
    waddr = 16'h0300; wdata = 32'h55AA55AA; wstrb = 4'hF; wen = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (psel !== 1'b1 || penable !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_in_access: got psel=%b penable=%b want 1 1",
               psel, penable);
    end
    rst = 1'b1;
    #1;
    total++;
    if (psel !== 1'b0 || penable !== 1'b0 || wready !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_async: got psel=%b penable=%b wready=%b err=%b want 0",
               psel, penable, wready, err);
    end
    @(negedge clk);
    rst = 1'b0;
    wen = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (psel !== 1'b0 || wready !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_idle: got psel=%b wready=%b want 0 0", psel, wready);
    end
    lb_xact(1'b0, 16'h0030, '0, '0, 2, 1'b0, 32'h600DF00D,
            lat, gw, gr, ge, gd, pb);
    model_rdata = 32'h600DF00D;
    total++;
    if (lat !== 5 || gr !== 1'b1 || ge !== 1'b0 || gd !== 32'h600DF00D) begin
      bad++;
      $display("FAIL rstmid_fresh_read: got lat=%0d rvalid=%b err=%b rdata=%h want 5 1 0 600df00d",
               lat, gr, ge, gd);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      bit            is_wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [DW-1:0] prd;
      logic [SW-1:0] strb;
      int            w;
      bit            se;
      bit            tout;
      int            lat;
      logic          gw, gr, ge, pb;
      logic [DW-1:0] gd;
      is_wr = 1'($urandom_range(0, 1));
      addr  = AW'($urandom);
      data  = DW'($urandom);
      prd   = DW'($urandom);
      strb  = SW'($urandom_range(1, 15));
      w     = $urandom_range(0, TO + 1);
      se    = ($urandom_range(0, 7) == 0);
      tout  = (w >= TO);
      lb_xact(is_wr, addr, data, strb, w, se, prd, lat, gw, gr, ge, gd, pb);
      if (!is_wr) model_rdata = tout ? '0 : prd;
      total++;
      if (lat !== exp_lat(w) || acc_cnt !== exp_acc(w) || gw !== is_wr ||
          gr !== !is_wr || ge !== (tout | se) || pb !== 1'b0) begin
        bad++;
        $display("FAIL rand%0d_resp: got lat=%0d acc=%0d wr=%b rd=%b err=%b busy=%b want %0d %0d %b %b %b 0",
                 i, lat, acc_cnt, gw, gr, ge, pb, exp_lat(w), exp_acc(w),
                 is_wr, !is_wr, tout | se);
      end
      total++;
      if (seen_addr !== addr || seen_write !== is_wr || apb_unstable !== 1'b0 ||
          seen_strb !== (is_wr ? strb : 4'hF) ||
          (is_wr && seen_wdata !== data)) begin
        bad++;
        $display("FAIL rand%0d_apb: got addr=%h wr=%b strb=%h data=%h unstable=%b want %h %b",
                 i, seen_addr, seen_write, seen_strb, seen_wdata, apb_unstable,
                 addr, is_wr);
      end
      total++;
      if (rdata !== model_rdata) begin
        bad++;
        $display("FAIL rand%0d_rdata: got %h want %h", i, rdata, model_rdata);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_waits();
    test_back_to_back();
    test_slverr();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d",
             total, bad);
    $fatal(1, "watchdog");
  end

endmodule
